// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide request and result bundle.
interface ex_muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inRD1;
    logic [31:0] inRD2;
    logic        busy;
    logic        done;
    logic [31:0] outHi;
    logic [31:0] outLo;
    logic        divByZero;

    modport master (output start, op, inRD1, inRD2,
                    input  busy, done, outHi, outLo, divByZero);
    modport slave  (input  start, op, inRD1, inRD2,
                    output busy, done, outHi, outLo, divByZero);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: one bit per cycle on sign magnitudes,
// sign fix-up on the final cycle, fixed 33-cycle start-to-done latency.
module ex_muldiv_unit (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        is_div, neg_q, neg_r;
    logic [31:0] a_q, a_mag, b_mag, hi, lo;
    logic [31:0] out_hi, out_lo;
    logic        out_dbz;

    // Operand magnitudes at capture; op[0]=0 selects the signed variants.
    logic        sgn;
    logic [31:0] in_a_mag, in_b_mag;
    assign sgn      = ~bus.op[0];
    assign in_a_mag = (sgn && bus.inRD1[31]) ? -bus.inRD1 : bus.inRD1;
    assign in_b_mag = (sgn && bus.inRD2[31]) ? -bus.inRD2 : bus.inRD2;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == 6'd32) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: {hi,lo} is the shift-add product register for multiply,
    // or {remainder, dividend/quotient} for restoring division.
    logic [32:0] msum, rsh, rdiff;
    logic        ge;
    logic [31:0] hi_step, lo_step;

    always_comb begin
        msum  = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : 33'd0);
        rsh   = {hi, lo[31]};
        rdiff = rsh - {1'b0, b_mag};
        ge    = (rsh >= {1'b0, b_mag});
        if (is_div) begin
            hi_step = ge ? rdiff[31:0] : rsh[31:0];
            lo_step = {lo[30:0], ge};
        end else begin
            hi_step = msum[32:1];
            lo_step = {msum[0], lo[31:1]};
        end
    end

    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;
    logic        dbz;

    always_comb begin
        prod = neg_q ? -{hi, lo} : {hi, lo};
        dbz  = is_div && (b_mag == 32'd0);
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (dbz) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = neg_r ? -hi : hi;
            res_lo = neg_q ? -lo : lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            a_q     <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            hi      <= '0;
            lo      <= '0;
            out_hi  <= '0;
            out_lo  <= '0;
            out_dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    is_div <= bus.op[1];
                    a_q    <= bus.inRD1;
                    a_mag  <= in_a_mag;
                    b_mag  <= in_b_mag;
                    hi     <= '0;
                    lo     <= bus.op[1] ? in_a_mag : in_b_mag;
                    cnt    <= '0;
                    neg_q  <= sgn & (bus.inRD1[31] ^ bus.inRD2[31]);
                    neg_r  <= sgn & bus.inRD1[31];
                end
                CALC: if (cnt != 6'd32) begin
                    hi  <= hi_step;
                    lo  <= lo_step;
                    cnt <= cnt + 6'd1;
                end else begin
                    out_hi  <= res_hi;
                    out_lo  <= res_lo;
                    out_dbz <= dbz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.outHi     = out_hi;
    assign bus.outLo     = out_lo;
    assign bus.divByZero = out_dbz;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: timing, results, ignored start and reset abort.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   nassert = 0;
    int   nfail   = 0;

    ex_muldiv_unit_if bus();

    ex_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start at edge k, check latency/busy each cycle, results at k+33, hold at k+34.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit inject);
        bus.start = 1'b1; bus.op = op; bus.inRD1 = a; bus.inRD2 = b;
        step();
        bus.start = 1'b0; bus.inRD1 = ~a; bus.inRD2 = b ^ 32'h5A5A_0F0F;
        for (int j = 1; j <= 32; j++) begin
            step();
            if (inject && j == 4) begin
                bus.start = 1'b1; bus.op = 2'b01;
                bus.inRD1 = 32'hFFFF_FFFF; bus.inRD2 = 32'hFFFF_FFFF;
            end
            if (inject && j == 5) bus.start = 1'b0;
            chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, " early done"}, {31'd0, bus.done}, 32'd0);
        end
        step();
        chk({tag, " done"},  {31'd0, bus.done}, 32'd1);
        chk({tag, " busy@done"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " outHi"}, bus.outHi, ehi);
        chk({tag, " outLo"}, bus.outLo, elo);
        chk({tag, " dbz"},   {31'd0, bus.divByZero}, {31'd0, edbz});
        step();
        chk({tag, " done cleared"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " idle"},   {31'd0, bus.busy}, 32'd0);
        chk({tag, " hold hi"}, bus.outHi, ehi);
        chk({tag, " hold lo"}, bus.outLo, elo);
        chk({tag, " hold dbz"}, {31'd0, bus.divByZero}, {31'd0, edbz});
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.inRD1 = '0; bus.inRD2 = '0;
        step();
        bus.start = 1'b1;
        step();
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset hi",   bus.outHi, 32'd0);
        chk("reset lo",   bus.outLo, 32'd0);
        chk("reset dbz",  {31'd0, bus.divByZero}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        step();

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        run_op("div -7/2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("divu by 0", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("divu 9/3",  2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("div -5/0",  2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("mult 5x-6", 2'b00, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0, 1'b0);

        // Abort a MULTU with reset at k+10; outputs from the previous op are nonzero.
        bus.start = 1'b1; bus.op = 2'b01; bus.inRD1 = 32'h1234_5678; bus.inRD2 = 32'h9ABC_DEF0;
        step();
        bus.start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            chk("abort no done", {31'd0, bus.done}, 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort hi",   bus.outHi, 32'd0);
        chk("abort lo",   bus.outLo, 32'd0);
        run_op("multu after rst", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
